// File: rtl/ones_frame_acc.sv
// rtl/ones_frame_acc.sv - frame accumulator for per-byte population counts
module ones_frame_acc #(
  parameter int FRAME_LEN = 8,
  parameter int SUM_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       count,
  input  logic             count_vld,
  output logic             in_rdy,
  output logic [SUM_W-1:0] sum,
  output logic [3:0]       max_cnt,
  output logic             frame_err,
  output logic             sum_vld,
  input  logic             out_rdy
);

  // Index width; a one-sample frame still keeps a 1-bit index that never moves.
  localparam int IDX_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

  localparam logic ST_ACC  = 1'b0;
  localparam logic ST_DONE = 1'b1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);
  localparam logic [SUM_W-1:0] SUM_MAX  = {SUM_W{1'b1}};
  localparam logic [3:0]       CNT_CAP  = 4'd8;

  logic             state;
  logic [SUM_W-1:0] acc;
  logic [3:0]       mx;
  logic             er;
  logic [IDX_W-1:0] idx;

  logic [3:0]       clamped;
  logic             over;
  logic [SUM_W:0]   sum_wide;
  logic [SUM_W-1:0] acc_next;
  logic [3:0]       mx_next;
  logic             er_next;
  logic             accept;
  logic             last;

  // Handshake decode: ready only while collecting and never during reset.
  always_comb begin
    in_rdy  = (state == ST_ACC) & ~rst;
    sum_vld = (state == ST_DONE);
    accept  = count_vld & in_rdy;
    last    = (idx == LAST_IDX);
  end

  // Clamp the incoming count and fold it into the running statistics.
  // The sum is widened by one bit so the carry out doubles as the saturation flag.
  always_comb begin
    over     = (count > CNT_CAP);
    clamped  = over ? CNT_CAP : count;
    sum_wide = {1'b0, acc} + (SUM_W + 1)'(clamped);
    acc_next = sum_wide[SUM_W] ? SUM_MAX : sum_wide[SUM_W-1:0];
    mx_next  = (clamped > mx) ? clamped : mx;
    er_next  = er | over;
  end

  // Frame FSM: collect FRAME_LEN samples, publish, hold until downstream takes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_ACC;
      acc       <= '0;
      mx        <= '0;
      er        <= 1'b0;
      idx       <= '0;
      sum       <= '0;
      max_cnt   <= '0;
      frame_err <= 1'b0;
    end else begin
      case (state)
        ST_ACC: begin
          if (accept) begin
            if (last) begin
              // Publish including this sample and restart the accumulators clean.
              sum       <= acc_next;
              max_cnt   <= mx_next;
              frame_err <= er_next;
              acc       <= '0;
              mx        <= '0;
              er        <= 1'b0;
              idx       <= '0;
              state     <= ST_DONE;
            end else begin
              acc <= acc_next;
              mx  <= mx_next;
              er  <= er_next;
              idx <= idx + 1'b1;
            end
          end
        end
        ST_DONE: begin
          if (out_rdy) begin
            state <= ST_ACC;
          end
        end
        default: state <= ST_ACC;
      endcase
    end
  end

endmodule

// File: tb/tb_ones_frame_acc.sv
// tb/tb_ones_frame_acc.sv - scoreboard bench for ones_frame_acc
module tb_ones_frame_acc;

  localparam int FL = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  count = 4'd0;
  logic        count_vld = 1'b0;
  logic        out_rdy = 1'b0;

  logic        in_rdy_a, in_rdy_b;
  logic [15:0] sum_a;
  logic [4:0]  sum_b;
  logic [3:0]  max_a, max_b;
  logic        err_a, err_b;
  logic        vld_a, vld_b;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int s16;
    int s5;
    int mx;
    int er;
  } exp_t;

  exp_t exp_q[$];
  int   acc_q[$];
  bit   m_done = 1'b0;

  always #5 clk = ~clk;

  ones_frame_acc #(.FRAME_LEN(FL), .SUM_W(16)) dut_a (
    .clk(clk), .rst(rst), .count(count), .count_vld(count_vld),
    .in_rdy(in_rdy_a), .sum(sum_a), .max_cnt(max_a), .frame_err(err_a),
    .sum_vld(vld_a), .out_rdy(out_rdy)
  );

  ones_frame_acc #(.FRAME_LEN(FL), .SUM_W(5)) dut_b (
    .clk(clk), .rst(rst), .count(count), .count_vld(count_vld),
    .in_rdy(in_rdy_b), .sum(sum_b), .max_cnt(max_b), .frame_err(err_b),
    .sum_vld(vld_b), .out_rdy(out_rdy)
  );

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: list of accepted counts, frame result from plain arithmetic.
  always @(posedge clk) begin
    if (rst) begin
      acc_q.delete();
      exp_q.delete();
      m_done = 1'b0;
    end else if (!m_done) begin
      if (count_vld) begin
        acc_q.push_back(int'(count));
        if (acc_q.size() == FL) begin
          exp_t e;
          int total, mx, er;
          total = 0; mx = 0; er = 0;
          foreach (acc_q[i]) begin
            int c;
            c = (acc_q[i] > 8) ? 8 : acc_q[i];
            if (acc_q[i] > 8) er = 1;
            total += c;
            if (c > mx) mx = c;
          end
          e.s16 = (total > 65535) ? 65535 : total;
          e.s5  = (total > 31) ? 31 : total;
          e.mx  = mx;
          e.er  = er;
          exp_q.push_back(e);
          acc_q.delete();
          m_done = 1'b1;
        end
      end
    end else if (out_rdy) begin
      m_done = 1'b0;
    end
  end

  // Monitor: compare handshake signals every cycle and the result while valid.
  always @(negedge clk) begin
    chk("in_rdy_a", int'(in_rdy_a), int'(!m_done && !rst));
    chk("in_rdy_b", int'(in_rdy_b), int'(!m_done && !rst));
    chk("sum_vld_a", int'(vld_a), int'(m_done));
    chk("sum_vld_b", int'(vld_b), int'(m_done));
    if (vld_a || vld_b) begin
      if (exp_q.size() == 0) begin
        chk("result_pending", 0, 1);
      end else begin
        chk("sum16", int'(sum_a), exp_q[0].s16);
        chk("sum5", int'(sum_b), exp_q[0].s5);
        chk("max_a", int'(max_a), exp_q[0].mx);
        chk("max_b", int'(max_b), exp_q[0].mx);
        chk("err_a", int'(err_a), exp_q[0].er);
        chk("err_b", int'(err_b), exp_q[0].er);
        if (out_rdy && !rst) void'(exp_q.pop_front());
      end
    end
  end

  task automatic step(input logic r, input logic v, input logic [3:0] c, input logic o);
    rst = r; count_vld = v; count = c; out_rdy = o;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset with live-looking input.
    step(1'b1, 1'b1, 4'd5, 1'b0);
    step(1'b1, 1'b1, 4'd5, 1'b0);
    rst = 1'b0; count_vld = 1'b0;
    #2;
    chk("rst_in_rdy", int'(in_rdy_a), 1);
    chk("rst_sum_vld", int'(vld_a), 0);
    chk("rst_sum", int'(sum_a), 0);
    chk("rst_max", int'(max_a), 0);
    chk("rst_err", int'(err_a), 0);
    chk("rst_sum5", int'(sum_b), 0);
    @(posedge clk); #1;

    // Nominal 1..8 with downstream always ready.
    for (int i = 1; i <= 8; i++) step(1'b0, 1'b1, 4'(i), 1'b1);
    step(1'b0, 1'b0, 4'd0, 1'b1);

    // Backpressure: all 3s, then held 5 cycles while count 7 is offered.
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 4'd3, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 4'd7, 1'b0);
    step(1'b0, 1'b1, 4'd7, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 4'd7, 1'b1);
    step(1'b0, 1'b0, 4'd0, 1'b1);

    // Out-of-range sample, then a clean frame.
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 4'd1, 1'b1);
    step(1'b0, 1'b1, 4'd12, 1'b1);
    step(1'b0, 1'b0, 4'd0, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 4'd1, 1'b1);
    step(1'b0, 1'b0, 4'd0, 1'b1);

    // Saturation in the narrow instance.
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 4'd8, 1'b1);
    step(1'b0, 1'b0, 4'd0, 1'b1);

    // Mid-frame reset discards the partial frame.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 4'd6, 1'b1);
    step(1'b1, 1'b0, 4'd0, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 4'd2, 1'b1);
    step(1'b0, 1'b0, 4'd0, 1'b1);

    // Reset while a result is pending.
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 4'd4, 1'b0);
    step(1'b0, 1'b0, 4'd0, 1'b0);
    step(1'b1, 1'b0, 4'd0, 1'b0);

    // Random traffic with random backpressure and rare resets.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0),
           4'($urandom_range(0, 15)), ($urandom_range(0, 2) != 0));
    end

    // Drain.
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 4'd0, 1'b1);
    chk("drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ones_frame_acc.md
# ones_frame_acc

Downstream consumer of the combinational byte ones counter. Accepts one 4-bit population count per valid cycle and accumulates `FRAME_LEN` counts into a frame result. The result is the saturating sum, the maximum per-byte count, and an out-of-range flag. It is presented on a valid/ready output port and held under backpressure, which gives the datapath per-frame bit-density statistics.

## Interface
- `FRAME_LEN`, 8, number of accepted counts per frame; legal range ≥ 1.
- `SUM_W`, 16, width of the frame sum; legal range ≥ 4.

- `clk`  input  1  single clock; everything samples on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `count`  input  4  population count of one byte from the upstream counter.
- `count_vld`  input  1  `count` is valid this cycle.
- `in_rdy`  output  1  block accepts `count`; a transfer occurs when `count_vld & in_rdy`.
- `sum`  output  SUM_W  frame sum of the clamped counts, saturating.
- `max_cnt`  output  4  largest clamped count in the frame.
- `frame_err`  output  1  at least one count in the frame exceeded 8.
- `sum_vld`  output  1  frame result is valid.
- `out_rdy`  input  1  downstream accepts the result; a transfer occurs when `sum_vld & out_rdy`.

## Operation
- Two-state FSM, registered: `ACC` (collecting counts) and `DONE` (result held).
- `in_rdy = (state == ACC) & ~rst`.
- `sum_vld = (state == DONE)`.
- Internal registers: accumulator `acc[SUM_W-1:0]`, running max `mx[3:0]`, sticky error `er`, and sample index `idx` (0..FRAME_LEN-1).
- Clamping: an accepted `count` greater than 8 is treated as 8 for the sum and the max, and sets `er`.
- Accumulation saturates: `acc + clamped` caps at 2^SUM_W−1 and never wraps.
- On an accepted count in `ACC` with `idx < FRAME_LEN-1`:
  - update `acc`, `mx` and `er`;
  - `idx++`.
- On an accepted count in `ACC` with `idx == FRAME_LEN-1`:
  - load `sum`, `max_cnt` and `frame_err` with the values including this sample;
  - clear `acc`, `mx`, `er` and `idx` to 0;
  - go to `DONE`.
- `FRAME_LEN = 1`: every accepted count completes a frame.
- `DONE`:
  - `in_rdy = 0`; `count_vld` is ignored and no state changes;
  - `sum`, `max_cnt` and `frame_err` are held stable;
  - when `out_rdy = 1`, go to `ACC` on that edge.
- Outputs `sum`, `max_cnt` and `frame_err` keep their last values after the handshake until the next frame completes. They are meaningful only while `sum_vld = 1`.
- Reset at any time, including mid-frame or in `DONE` with a pending result:
  - state goes to `ACC`;
  - all registers and outputs go to 0;
  - a partially accumulated frame or an unconsumed result is discarded.

## Timing
- Reset values: `sum = 0`, `max_cnt = 0`, `frame_err = 0`, `sum_vld = 0`.
- `in_rdy` is 0 during `rst` and 1 in the first cycle after reset is released.
- Input acceptance: `ACC` sustains one count per cycle, with no bubbles inside a frame.
- Latency: the last sample of a frame is accepted at edge k. `sum_vld` is 1 from the cycle after edge k.
- Output handshake at edge m (`sum_vld & out_rdy`): `sum_vld = 0` and `in_rdy = 1` in the cycle after edge m.
- Throughput: minimum frame period is `FRAME_LEN + 1` cycles, because each frame has a single `DONE` cycle when `out_rdy` is held high.
- `out_rdy` is sampled only in `DONE`. `out_rdy` high in `ACC` has no effect.
- `count` is don't-care when `count_vld = 0` or `in_rdy = 0`.

## Test plan
- Reset: assert `rst` for 2 cycles with `count_vld = 1`, `count = 5`.
  - After release: `in_rdy = 1`, `sum_vld = 0`, `sum = 0`, `max_cnt = 0`, `frame_err = 0`.
  - The first accepted frame is unaffected by the `count` values driven during reset.
- Nominal frame (`FRAME_LEN = 8`): counts 1,2,…,8 on consecutive cycles, `out_rdy = 1`.
  - `sum_vld` is high for exactly 1 cycle, starting the cycle after the 8th acceptance.
  - Result: `sum = 36`, `max_cnt = 8`, `frame_err = 0`.
  - `in_rdy` is low in that cycle and high again the cycle after.
- Backpressure: complete a frame of all 3s with `out_rdy = 0` for 5 cycles, keeping `count_vld = 1` with `count = 7`.
  - `sum = 24`, `max_cnt = 3` and `sum_vld = 1` hold stable; `in_rdy = 0`.
  - After `out_rdy` rises, the next frame starts from zero, so its first count 7 gives that frame `max_cnt ≥ 7`.
- Out-of-range input: frame of seven 1s plus one `count = 12`.
  - Result: `sum = 15`, `max_cnt = 8`, `frame_err = 1`.
  - A following frame of eight 1s gives `sum = 8`, `max_cnt = 1`, `frame_err = 0`.
- Saturation (`SUM_W = 5`, `FRAME_LEN = 8`): eight counts of 8.
  - Result: `sum = 31`, with no wrap to 0; `max_cnt = 8`.
- Mid-frame reset: accept 3 counts of 6, pulse `rst` for 1 cycle, then send a full frame of 2s.
  - Result: `sum = 16`, `max_cnt = 2`, `frame_err = 0`; `sum_vld` was never asserted for the aborted frame.
